// File: rtl/encoder_16_4_pending.sv
// encoder_16_4_pending: latches event pulses into a pending vector and hands them to a consumer one index at a time
// Lines are picked either by fixed lowest-index priority (RR=0) or round-robin from the last loaded line (RR=1).
module encoder_16_4_pending #(
    parameter int RR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    output logic [3:0]  out_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] pending,
    output logic        overflow,
    input  logic        overflow_clr
);
    logic [3:0]  ptr;
    logic [3:0]  start;
    logic [3:0]  idx;
    logic [3:0]  sel;
    logic        found;
    logic        load;
    logic [15:0] load_mask;
    logic        lost;

    assign start = (RR != 0) ? ptr + 4'd1 : 4'd0;

    always_comb begin
        sel   = 4'd0;
        found = 1'b0;
        idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            idx = start + 4'(i);
            if (!found && pending[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign load      = (!out_valid || out_ready) && found;
    assign load_mask = load ? 16'(1) << sel : 16'h0000;
    // A line being handed out this edge can take a fresh event without loss.
    assign lost      = |(req & pending & ~load_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= 16'h0000;
            out_code  <= 4'h0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            ptr       <= 4'd15;
        end else begin
            pending  <= (pending & ~load_mask) | req;
            overflow <= lost || (overflow && !overflow_clr);
            if (!out_valid || out_ready)
                out_valid <= found;
            if (load) begin
                out_code <= sel;
                ptr      <= sel;
            end
        end
    end
endmodule

// File: tb/tb_encoder_16_4_pending.sv
// tb_encoder_16_4_pending: directed vectors for fixed-priority and round-robin instances sharing one stimulus.
module tb_encoder_16_4_pending;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = 16'h0000;
    logic        out_ready = 1'b0;
    logic        overflow_clr = 1'b0;
    logic [3:0]  code0, code1;
    logic        valid0, valid1, ovf0, ovf1;
    logic [15:0] pend0, pend1;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [15:0] req;
        logic        rdy;
        logic        clr;
        logic [3:0]  code;
        logic        valid;
        logic [15:0] pend;
        logic        ovf;
    } vec_t;
    vec_t tv[22];

    encoder_16_4_pending #(.RR(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .out_code(code0), .out_valid(valid0),
        .out_ready(out_ready), .pending(pend0), .overflow(ovf0), .overflow_clr(overflow_clr)
    );
    encoder_16_4_pending #(.RR(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .out_code(code1), .out_valid(valid1),
        .out_ready(out_ready), .pending(pend1), .overflow(ovf1), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 16'h0000;
        out_ready = 1'b0;
        overflow_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        tv[0]  = '{16'h0024, 1, 0, 4'd0,  0, 16'h0024, 0};
        tv[1]  = '{16'h0000, 1, 0, 4'd2,  1, 16'h0020, 0};
        tv[2]  = '{16'h0000, 1, 0, 4'd5,  1, 16'h0000, 0};
        tv[3]  = '{16'h0000, 1, 0, 4'd5,  0, 16'h0000, 0};
        tv[4]  = '{16'h8001, 0, 0, 4'd5,  0, 16'h8001, 0};
        tv[5]  = '{16'h0000, 0, 0, 4'd0,  1, 16'h8000, 0};
        tv[6]  = '{16'h0000, 0, 0, 4'd0,  1, 16'h8000, 0};
        tv[7]  = '{16'h0000, 1, 0, 4'd15, 1, 16'h0000, 0};
        tv[8]  = '{16'h0000, 0, 0, 4'd15, 1, 16'h0000, 0};
        tv[9]  = '{16'h0000, 1, 0, 4'd15, 0, 16'h0000, 0};
        tv[10] = '{16'h0008, 0, 0, 4'd15, 0, 16'h0008, 0};
        tv[11] = '{16'h0000, 0, 0, 4'd3,  1, 16'h0000, 0};
        tv[12] = '{16'h0008, 0, 0, 4'd3,  1, 16'h0008, 0};
        tv[13] = '{16'h0008, 0, 0, 4'd3,  1, 16'h0008, 1};
        tv[14] = '{16'h0000, 0, 1, 4'd3,  1, 16'h0008, 0};
        tv[15] = '{16'h0008, 0, 1, 4'd3,  1, 16'h0008, 1};
        tv[16] = '{16'h0000, 0, 1, 4'd3,  1, 16'h0008, 0};
        tv[17] = '{16'h0000, 1, 0, 4'd3,  1, 16'h0000, 0};
        tv[18] = '{16'h0010, 1, 0, 4'd3,  0, 16'h0010, 0};
        tv[19] = '{16'h0010, 1, 0, 4'd4,  1, 16'h0010, 0};
        tv[20] = '{16'h0000, 1, 0, 4'd4,  1, 16'h0000, 0};
        tv[21] = '{16'h0000, 1, 0, 4'd4,  0, 16'h0000, 0};

        do_reset();
        chk("reset_code", 16'(code0), 16'h0);
        chk("reset_valid", 16'(valid0), 16'h0);
        chk("reset_pending", pend0, 16'h0000);
        chk("reset_overflow", 16'(ovf0), 16'h0);

        for (int i = 0; i < 22; i++) begin
            req = tv[i].req;
            out_ready = tv[i].rdy;
            overflow_clr = tv[i].clr;
            step();
            chk($sformatf("v%0d_code", i), 16'(code0), 16'(tv[i].code));
            chk($sformatf("v%0d_valid", i), 16'(valid0), 16'(tv[i].valid));
            chk($sformatf("v%0d_pending", i), pend0, tv[i].pend);
            chk($sformatf("v%0d_overflow", i), 16'(ovf0), 16'(tv[i].ovf));
        end

        // Round-robin sweep from the reset pointer.
        do_reset();
        req = 16'hFFFF;
        out_ready = 1'b1;
        step();
        chk("rr_fill_pending", pend1, 16'hFFFF);
        chk("rr_fill_valid", 16'(valid1), 16'h0);
        req = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            step();
            chk($sformatf("rr%0d_code", k), 16'(code1), 16'(k));
            chk($sformatf("rr%0d_valid", k), 16'(valid1), 16'h1);
            chk($sformatf("rr%0d_pending", k), pend1, 16'hFFFF << (k + 1));
        end
        step();
        chk("rr_end_valid", 16'(valid1), 16'h0);
        chk("rr_end_code", 16'(code1), 16'hF);

        // Pointer is at 15, so the next search wraps to 0 before 1.
        req = 16'h0003;
        step();
        req = 16'h0000;
        step();
        chk("rr_wrap_code", 16'(code1), 16'h0);
        step();
        chk("rr_wrap_next", 16'(code1), 16'h1);

        // Asynchronous reset while events are held.
        do_reset();
        req = 16'h00F0;
        out_ready = 1'b0;
        step();
        step();
        req = 16'h0000;
        chk("pre_rst_pending", pend0, 16'h00F0);
        chk("pre_rst_valid", 16'(valid0), 16'h1);
        chk("pre_rst_code", 16'(code0), 16'h4);
        chk("pre_rst_overflow", 16'(ovf0), 16'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_pending", pend0, 16'h0000);
        chk("async_valid", 16'(valid0), 16'h0);
        chk("async_code", 16'(code0), 16'h0);
        chk("async_overflow", 16'(ovf0), 16'h0);
        req = 16'h0002;
        step();
        chk("rst_ignores_req", pend0, 16'h0000);
        rst = 1'b0;
        step();
        chk("resume_pending", pend0, 16'h0002);
        req = 16'h0000;
        step();
        chk("resume_code", 16'(code0), 16'h1);
        chk("resume_valid", 16'(valid0), 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
